// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : load_store_unit
// Brief    : MEM-stage load/store engine. It takes one request at a time and
//            issues word-aligned accesses with byte enables, splitting a
//            word-crossing access into two.
// Revision : 1.0 - initial release
// ============================================================================
module load_store_unit #(
    parameter int ADDR_WIDTH       = 32,
    parameter int MEM_SIZE         = 2097152,
    parameter int ALLOW_MISALIGNED = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [31:0]           req_wdata,
    input  logic [2:0]            req_funct3,
    output logic                  resp_valid,
    output logic [31:0]           resp_rdata,
    output logic                  resp_error,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [31:0]           mem_wdata,
    output logic                  mem_we,
    output logic [3:0]            mem_be,
    output logic                  mem_re,
    output logic [2:0]            mem_load_type,
    input  logic [31:0]           mem_rdata
);

    localparam logic [ADDR_WIDTH:0] c_mem_size  = (ADDR_WIDTH+1)'(MEM_SIZE);
    localparam logic [2:0]          c_word_read = 3'b010;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ACC0 = 2'd1,
        S_ACC1 = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t        r_state;
    logic          r_write;
    logic [2:0]    r_funct3;
    logic [1:0]    r_offset;
    logic [3:0]    r_be_hi;
    logic [31:0]   r_wdata_hi;
    logic [31:0]   r_lo_buf;
    logic          r_mem_we;

    logic [1:0]            w_size_m1;
    logic [3:0]            w_size_mask;
    logic [7:0]            w_mask;
    logic [63:0]           w_wdata_sh;
    logic [ADDR_WIDTH:0]   w_last;
    logic                  w_f3_ok;
    logic                  w_range_ok;
    logic                  w_align_ok;
    logic                  w_legal;

    always_comb begin
        case (req_funct3[1:0])
            2'b00:   begin w_size_m1 = 2'd0; w_size_mask = 4'b0001; end
            2'b01:   begin w_size_m1 = 2'd1; w_size_mask = 4'b0011; end
            default: begin w_size_m1 = 2'd3; w_size_mask = 4'b1111; end
        endcase
        if (req_write)
            w_f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010};
        else
            w_f3_ok = req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        // One extra bit so the last-byte address cannot wrap past zero.
        w_last     = {1'b0, req_addr} + (ADDR_WIDTH+1)'(w_size_m1);
        w_range_ok = (w_last < c_mem_size);
        w_align_ok = (ALLOW_MISALIGNED != 0) || ((req_addr[1:0] & w_size_m1) == 2'b00);
        w_legal    = w_f3_ok && w_range_ok && w_align_ok;
        w_mask     = {4'b0000, w_size_mask} << req_addr[1:0];
        w_wdata_sh = {32'h0, req_wdata} << {req_addr[1:0], 3'b000};
    end

    // Realign the (possibly two-word) read data and extend to 32 bits.
    function automatic logic [31:0] extend(input logic [31:0] lo, input logic [31:0] hi,
                                           input logic [1:0] off, input logic [2:0] f3);
        logic [63:0] sh;
        sh = {hi, lo} >> {off, 3'b000};
        case (f3)
            3'b000:  return {{24{sh[7]}}, sh[7:0]};
            3'b001:  return {{16{sh[15]}}, sh[15:0]};
            3'b100:  return {24'h0, sh[7:0]};
            3'b101:  return {16'h0, sh[15:0]};
            default: return sh[31:0];
        endcase
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_error <= 1'b0;
            resp_rdata <= 32'h0;
            mem_addr   <= '0;
            mem_wdata  <= 32'h0;
            mem_be     <= 4'h0;
            mem_re     <= 1'b0;
            r_mem_we   <= 1'b0;
            r_write    <= 1'b0;
            r_funct3   <= 3'b000;
            r_offset   <= 2'b00;
            r_be_hi    <= 4'h0;
            r_wdata_hi <= 32'h0;
            r_lo_buf   <= 32'h0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        req_ready <= 1'b0;
                        r_write   <= req_write;
                        r_funct3  <= req_funct3;
                        r_offset  <= req_addr[1:0];
                        if (w_legal) begin
                            r_state    <= S_ACC0;
                            mem_addr   <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_be     <= w_mask[3:0];
                            mem_wdata  <= w_wdata_sh[31:0];
                            r_mem_we   <= req_write;
                            mem_re     <= ~req_write;
                            r_be_hi    <= w_mask[7:4];
                            r_wdata_hi <= w_wdata_sh[63:32];
                        end else begin
                            r_state    <= S_RESP;
                            resp_valid <= 1'b1;
                            resp_error <= 1'b1;
                            resp_rdata <= 32'h0;
                        end
                    end
                end
                S_ACC0: begin
                    r_lo_buf <= mem_rdata;
                    if (r_be_hi != 4'h0) begin
                        r_state   <= S_ACC1;
                        mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                        mem_be    <= r_be_hi;
                        mem_wdata <= r_wdata_hi;
                    end else begin
                        r_state    <= S_RESP;
                        r_mem_we   <= 1'b0;
                        mem_re     <= 1'b0;
                        mem_be     <= 4'h0;
                        resp_valid <= 1'b1;
                        resp_error <= 1'b0;
                        resp_rdata <= r_write ? 32'h0 : extend(mem_rdata, 32'h0, r_offset, r_funct3);
                    end
                end
                S_ACC1: begin
                    r_state    <= S_RESP;
                    r_mem_we   <= 1'b0;
                    mem_re     <= 1'b0;
                    mem_be     <= 4'h0;
                    resp_valid <= 1'b1;
                    resp_error <= 1'b0;
                    resp_rdata <= r_write ? 32'h0 : extend(r_lo_buf, mem_rdata, r_offset, r_funct3);
                end
                S_RESP: begin
                    r_state    <= S_IDLE;
                    resp_valid <= 1'b0;
                    resp_error <= 1'b0;
                    resp_rdata <= 32'h0;
                    req_ready  <= 1'b1;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // A reset arriving mid-split must suppress the second half-write in that cycle.
    assign mem_we        = r_mem_we & ~rst;
    assign mem_load_type = c_word_read;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_load_store_unit
// Brief    : Self-checking bench for load_store_unit: directed table, random
//            traffic against a byte-level memory model, multi-cycle corners.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_load_store_unit;

    localparam int AW    = 32;
    localparam int MSIZE = 2097152;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        resp_valid, resp_error;
    logic [31:0] resp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we, mem_re;
    logic [3:0]  mem_be;
    logic [2:0]  mem_load_type;

    logic        na_req_valid, na_req_ready, na_req_write;
    logic [31:0] na_req_addr, na_req_wdata;
    logic [2:0]  na_req_funct3;
    logic        na_resp_valid, na_resp_error;
    logic [31:0] na_resp_rdata, na_mem_addr, na_mem_wdata, na_mem_rdata;
    logic        na_mem_we, na_mem_re;
    logic [3:0]  na_mem_be;
    logic [2:0]  na_mem_load_type;

    load_store_unit #(.ADDR_WIDTH(AW), .MEM_SIZE(MSIZE), .ALLOW_MISALIGNED(1)) u_dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_funct3(req_funct3), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_error(resp_error), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .mem_be(mem_be), .mem_re(mem_re),
        .mem_load_type(mem_load_type), .mem_rdata(mem_rdata)
    );

    load_store_unit #(.ADDR_WIDTH(AW), .MEM_SIZE(MSIZE), .ALLOW_MISALIGNED(0)) u_dut_na (
        .clk(clk), .rst(rst), .req_valid(na_req_valid), .req_ready(na_req_ready),
        .req_write(na_req_write), .req_addr(na_req_addr), .req_wdata(na_req_wdata),
        .req_funct3(na_req_funct3), .resp_valid(na_resp_valid), .resp_rdata(na_resp_rdata),
        .resp_error(na_resp_error), .mem_addr(na_mem_addr), .mem_wdata(na_mem_wdata),
        .mem_we(na_mem_we), .mem_be(na_mem_be), .mem_re(na_mem_re),
        .mem_load_type(na_mem_load_type), .mem_rdata(na_mem_rdata)
    );

    assign na_mem_rdata = 32'hCAFEBABE;

    // Byte memory seen by the DUT (aliased to 64 KiB) and the model's own copy.
    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    logic       init_mem;
    logic [15:0] w_base;
    assign w_base    = {mem_addr[15:2], 2'b00};
    assign mem_rdata = {mem[w_base + 16'd3], mem[w_base + 16'd2], mem[w_base + 16'd1], mem[w_base]};

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 37 + 11) ^ (i >> 8));
    endfunction

    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
        end else if (mem_we) begin
            for (int i = 0; i < 4; i++)
                if (mem_be[i]) mem[w_base + 16'(i)] <= mem_wdata[8*i +: 8];
        end
    end

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%h required=%h", name, act, exp);
        end
    endtask

    // Results of the last request, plus the trace of memory accesses it made.
    logic [31:0] last_rdata;
    logic        last_err;
    int          last_lat;
    logic [31:0] tr_addr[$];
    logic [3:0]  tr_be[$];
    logic [31:0] tr_wd[$];
    logic        tr_we[$];

    task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3);
        tr_addr.delete(); tr_be.delete(); tr_wd.delete(); tr_we.delete();
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = wd; req_funct3 = f3;
        check("req_ready_idle", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        last_lat = 99; last_rdata = 'x; last_err = 1'bx;
        for (int n = 1; n <= 6; n++) begin
            @(negedge clk);
            if (mem_we || mem_re) begin
                tr_addr.push_back(mem_addr); tr_be.push_back(mem_be);
                tr_wd.push_back(mem_wdata);  tr_we.push_back(mem_we);
            end
            if (resp_valid) begin
                last_lat = n; last_rdata = resp_rdata; last_err = resp_error;
                break;
            end
        end
        if (last_lat == 99) begin
            checks++; errors++;
            $display("FAIL resp_timeout: actual=no resp_valid required=resp_valid within 6 cycles");
        end else begin
            @(negedge clk);
            check("resp_single_pulse", 32'(resp_valid), 32'd0);
        end
    endtask

    // Behavioural model: byte-addressed little-endian memory plus legality rules.
    task automatic ref_access(input logic wr, input logic [31:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] rd,
                              output logic err, output int lat);
        int sz;
        bit legal;
        logic [63:0] v;
        sz = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        legal = wr ? (f3 inside {3'd0, 3'd1, 3'd2}) : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
        if (longint'(a) + sz - 1 >= MSIZE) legal = 1'b0;
        rd = 32'h0; err = !legal; lat = 1;
        if (legal) begin
            lat = ((a % 4) + sz > 4) ? 3 : 2;
            if (wr) begin
                for (int i = 0; i < sz; i++) ref_mem[16'(a + i)] = wd[8*i +: 8];
            end else begin
                v = 64'h0;
                for (int i = sz - 1; i >= 0; i--) v = (v << 8) | 64'(ref_mem[16'(a + i)]);
                if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (~64'h0 << (8 * sz));
                rd = v[31:0];
            end
        end
    endtask

    task automatic run_and_check(input string tag, input logic wr, input logic [31:0] a,
                                 input logic [31:0] wd, input logic [2:0] f3,
                                 input logic [31:0] exp_rd, input logic exp_err, input int exp_lat);
        do_req(wr, a, wd, f3);
        check({tag, ".rdata"},    last_rdata, exp_rd);
        check({tag, ".error"},    32'(last_err), 32'(exp_err));
        check({tag, ".latency"},  32'(last_lat), 32'(exp_lat));
        check({tag, ".accesses"}, 32'(tr_addr.size()), 32'((exp_lat == 1) ? 0 : exp_lat - 1));
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  f3;
        logic [31:0] rd;
        logic        err;
        int          lat;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] m_rd;
    logic        m_err;
    int          m_lat;
    logic [7:0]  old4, old5;
    logic        seen;
    logic [2:0]  legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    initial begin
        rst = 1'b1; init_mem = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_funct3 = '0;
        na_req_valid = 1'b0; na_req_write = 1'b0; na_req_addr = '0; na_req_wdata = '0; na_req_funct3 = '0;
        for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset.req_ready",  32'(req_ready),  32'd1);
        check("reset.resp_valid", 32'(resp_valid), 32'd0);
        check("reset.resp_error", 32'(resp_error), 32'd0);
        check("reset.resp_rdata", resp_rdata,      32'd0);
        check("reset.mem_we_re",  {30'd0, mem_we, mem_re}, 32'd0);
        check("reset.mem_be",     32'(mem_be),     32'd0);
        check("reset.mem_addr",   mem_addr,        32'd0);
        check("reset.mem_wdata",  mem_wdata,       32'd0);
        check("reset.load_type",  32'(mem_load_type), 32'd2);
        check("reset.na_ready",   32'(na_req_ready), 32'd1);
        rst = 1'b0; init_mem = 1'b0;

        // Aligned word store: single access, full byte enables.
        ref_access(1'b1, 32'h100, 32'h11223344, 3'b010, m_rd, m_err, m_lat);
        do_req(1'b1, 32'h100, 32'h11223344, 3'b010);
        check("sw100.latency", 32'(last_lat), 32'd2);
        check("sw100.accesses", 32'(tr_addr.size()), 32'd1);
        check("sw100.be", 32'(tr_be[0]), 32'hF);
        check("sw100.wdata", tr_wd[0], 32'h11223344);

        // Crossing word store: two accesses with split lanes.
        ref_access(1'b1, 32'h302, 32'hAABBCCDD, 3'b010, m_rd, m_err, m_lat);
        do_req(1'b1, 32'h302, 32'hAABBCCDD, 3'b010);
        check("sw302.latency", 32'(last_lat), 32'd3);
        check("sw302.accesses", 32'(tr_addr.size()), 32'd2);
        check("sw302.addr0", tr_addr[0], 32'h300);
        check("sw302.be0", 32'(tr_be[0]), 32'hC);
        check("sw302.wdata0", tr_wd[0], 32'hCCDD0000);
        check("sw302.addr1", tr_addr[1], 32'h304);
        check("sw302.be1", 32'(tr_be[1]), 32'h3);
        check("sw302.wdata1", tr_wd[1], 32'h0000AABB);
        check("sw302.we", {30'd0, tr_we[0], tr_we[1]}, 32'd3);

        vecs.push_back('{1'b0, 32'h103, 32'h0, 3'b000, 32'h00000011, 1'b0, 2});
        vecs.push_back('{1'b1, 32'h200, 32'h80FF7F01, 3'b010, 32'h0, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h201, 32'h0, 3'b001, 32'hFFFFFF7F, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h201, 32'h0, 3'b101, 32'h0000FF7F, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h203, 32'h0, 3'b000, 32'hFFFFFF80, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h302, 32'h0, 3'b010, 32'hAABBCCDD, 1'b0, 3});
        vecs.push_back('{1'b0, 32'h303, 32'h0, 3'b001, 32'hFFFFBBCC, 1'b0, 3});
        vecs.push_back('{1'b0, 32'h303, 32'h0, 3'b101, 32'h0000BBCC, 1'b0, 3});
        vecs.push_back('{1'b0, 32'h305, 32'h0, 3'b100, 32'h000000AA, 1'b0, 2});
        vecs.push_back('{1'b0, 32'h0,   32'h0, 3'b011, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 32'h0,   32'h0, 3'b110, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 32'h0,   32'h0, 3'b111, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 32'h0,   32'h55, 3'b100, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b1, 32'(MSIZE - 1), 32'h1234, 3'b001, 32'h0, 1'b1, 1});
        vecs.push_back('{1'b0, 32'(MSIZE - 3), 32'h0, 3'b010, 32'h0, 1'b1, 1});
        foreach (vecs[i]) begin
            ref_access(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].f3, m_rd, m_err, m_lat);
            run_and_check($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                          vecs[i].f3, vecs[i].rd, vecs[i].err, vecs[i].lat);
        end

        // Reset during the second half of a crossing store.
        old4 = mem[16'h404]; old5 = mem[16'h405];
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h402; req_wdata = 32'hAABBCCDD; req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        check("rst.acc0_we", 32'(mem_we), 32'd1);
        @(negedge clk);
        check("rst.acc1_addr", mem_addr, 32'h404);
        seen = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        seen = seen | resp_valid;
        check("rst.req_ready", 32'(req_ready), 32'd1);
        rst = 1'b0;
        repeat (3) begin
            @(negedge clk);
            seen = seen | resp_valid;
        end
        check("rst.no_resp", 32'(seen), 32'd0);
        check("rst.byte402", 32'(mem[16'h402]), 32'hDD);
        check("rst.byte403", 32'(mem[16'h403]), 32'hCC);
        check("rst.byte404", 32'(mem[16'h404]), 32'(old4));
        check("rst.byte405", 32'(mem[16'h405]), 32'(old5));
        ref_mem[16'h402] = 8'hDD;
        ref_mem[16'h403] = 8'hCC;

        // Alignment-checking instance.
        @(negedge clk);
        na_req_valid = 1'b1; na_req_write = 1'b0; na_req_addr = 32'h101; na_req_funct3 = 3'b001;
        @(posedge clk);
        #1;
        na_req_valid = 1'b0;
        @(negedge clk);
        check("na.lh101.valid", 32'(na_resp_valid), 32'd1);
        check("na.lh101.error", 32'(na_resp_error), 32'd1);
        check("na.lh101.rdata", na_resp_rdata, 32'd0);
        @(negedge clk);
        na_req_valid = 1'b1; na_req_addr = 32'h104; na_req_funct3 = 3'b010;
        @(posedge clk);
        #1;
        na_req_valid = 1'b0;
        @(negedge clk);
        check("na.lw104.acc", {na_resp_valid, na_mem_re, na_mem_addr[29:0]}, {2'b01, 30'h104});
        @(negedge clk);
        check("na.lw104.valid", 32'(na_resp_valid), 32'd1);
        check("na.lw104.error", 32'(na_resp_error), 32'd0);
        check("na.lw104.rdata", na_resp_rdata, 32'hCAFEBABE);

        // Random traffic against the model.
        for (int it = 0; it < 300; it++) begin
            logic        wr;
            logic [31:0] a, wd;
            logic [2:0]  f3;
            int          k;
            wr = 1'($urandom_range(0, 1));
            wd = $urandom;
            k  = $urandom_range(0, 7);
            f3 = (k < 5) ? legal_f3[k] : 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) a = 32'(MSIZE - $urandom_range(1, 4));
            else a = 32'($urandom_range(0, 'h7FF));
            ref_access(wr, a, wd, f3, m_rd, m_err, m_lat);
            run_and_check($sformatf("rnd%0d", it), wr, a, wd, f3, m_rd, m_err, m_lat);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
